// File: rtl/frame_pingpong_ctrl_if.sv
// frame_pingpong_ctrl_if: column-write and pixel-read handshake bundle of the ping-pong frame buffer
interface frame_pingpong_ctrl_if #(
  parameter int CW     = 5,
  parameter int ADDR_W = 10
);
  logic              col_valid;
  logic              col_accept;
  logic              wr_en;
  logic              wr_bank;
  logic [CW-1:0]     wr_col;
  logic              rd_en;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;
  logic [1:0]        bank_full;
  logic              frame_done;
  modport master (
    input  col_valid, pix_ready,
    output col_accept, wr_en, wr_bank, wr_col, rd_en, rd_bank, rd_addr,
           pix_valid, pix_sof, pix_eol, bank_full, frame_done
  );
  modport slave (
    output col_valid, pix_ready,
    input  col_accept, wr_en, wr_bank, wr_col, rd_en, rd_bank, rd_addr,
           pix_valid, pix_sof, pix_eol, bank_full, frame_done
  );
endinterface

// File: rtl/frame_pingpong_ctrl.sv
// frame_pingpong_ctrl: two-bank ping-pong sequencer, whole columns in, raster-order pixel reads out.
// Define DROP_COUNT_EN to add a saturating drop_count output for rejected columns.
module frame_pingpong_ctrl #(
  parameter int X_SIZE = 24,
  parameter int Y_SIZE = 24,
  parameter int ADDR_W = 10,
  parameter int CW     = 5
) (
  input logic                   out_stream_aclk,
  input logic                   periph_resetn,
  frame_pingpong_ctrl_if.master bus
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;
  bank_st_t st [2];
  logic [CW-1:0] x, y;
  logic rd_done, pix_last, wr_last, x_last, y_last, rel;
  assign wr_last = bus.wr_col == CW'(X_SIZE - 1);
  assign x_last = x == CW'(X_SIZE - 1);
  assign y_last = y == CW'(Y_SIZE - 1);
  // col_accept is gated by reset so no write strobe can escape while reset is held
  assign bus.col_accept = periph_resetn && (st[bus.wr_bank] == EMPTY || st[bus.wr_bank] == FILLING);
  assign bus.wr_en = bus.col_valid && bus.col_accept;
  assign bus.rd_en = st[bus.rd_bank] == DRAINING && !rd_done && (!bus.pix_valid || bus.pix_ready);
  assign bus.rd_addr = ADDR_W'(y) * ADDR_W'(X_SIZE) + ADDR_W'(x);
  assign rel = bus.pix_valid && bus.pix_ready && pix_last;
  assign bus.frame_done = rel;
  assign bus.bank_full = {st[1] == FULL || st[1] == DRAINING, st[0] == FULL || st[0] == DRAINING};
  always_ff @(posedge out_stream_aclk or negedge periph_resetn)
    if (!periph_resetn) begin
      st <= '{EMPTY, EMPTY};
      bus.wr_bank <= 1'b0;
      bus.wr_col <= '0;
      bus.rd_bank <= 1'b0;
      x <= '0;
      y <= '0;
      rd_done <= 1'b0;
      pix_last <= 1'b0;
      bus.pix_valid <= 1'b0;
      bus.pix_sof <= 1'b0;
      bus.pix_eol <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        st[bus.wr_bank] <= wr_last ? FULL : FILLING;
        bus.wr_col <= wr_last ? '0 : bus.wr_col + 1'b1;
        if (wr_last) bus.wr_bank <= !bus.wr_bank;
      end
      if (rel) begin
        st[bus.rd_bank] <= EMPTY;
        bus.rd_bank <= !bus.rd_bank;
        rd_done <= 1'b0;
      end else if (st[bus.rd_bank] == FULL) st[bus.rd_bank] <= DRAINING;
      if (bus.rd_en) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= y_last ? '0 : y + 1'b1;
        rd_done <= x_last && y_last;
        pix_last <= x_last && y_last;
        bus.pix_sof <= x == '0 && y == '0;
        bus.pix_eol <= x_last;
      end
      bus.pix_valid <= bus.rd_en || (bus.pix_valid && !bus.pix_ready);
    end
`ifdef DROP_COUNT_EN
  always_ff @(posedge out_stream_aclk or negedge periph_resetn)
    if (!periph_resetn) drop_count <= '0;
    else if (bus.col_valid && !bus.col_accept && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
`endif
endmodule

// File: tb/tb_frame_pingpong_ctrl.sv
// tb_frame_pingpong_ctrl: scoreboard bench with a frame-level reference model and a BRAM model.
module tb_frame_pingpong_ctrl;
  localparam int X = 24;
  localparam int Y = 24;
  localparam int NPIX = X * Y;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  frame_pingpong_ctrl_if #(.CW(5), .ADDR_W(10)) bus ();
`ifdef DROP_COUNT_EN
  logic [15:0] drop_count;
`endif
  frame_pingpong_ctrl #(.X_SIZE(X), .Y_SIZE(Y), .ADDR_W(10), .CW(5)) dut (
    .out_stream_aclk(clk),
    .periph_resetn(rst_n),
    .bus(bus)
`ifdef DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );
  typedef struct { int fr; int addr; logic sof; logic eol; logic last; } pix_t;
  pix_t exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int W = 0;
  int R = 0;
  int col = 0;
  int mem [2][X];
  int d_fr = -1;
  int d_addr = -1;
  logic held = 1'b0;
  logic h_sof, h_eol;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask
  task automatic model_reset();
    W = 0;
    R = 0;
    col = 0;
    exp_q.delete();
    held = 1'b0;
    d_fr = -1;
    d_addr = -1;
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      logic [1:0] bf;
      pix_t e;
      int pend;
      pend = W - R;
      bf = '0;
      for (int k = R; k < W; k++) bf[k % 2] = 1'b1;
      chk("col_accept", bus.col_accept, pend < 2);
      chk("bank_full", bus.bank_full, bf);
      chk("wr_en", bus.wr_en, bus.col_valid && pend < 2);
      if (bus.col_valid && pend < 2) begin
        chk("wr_bank", bus.wr_bank, W % 2);
        chk("wr_col", bus.wr_col, col);
        mem[W % 2][col] = W;
        if (++col == X) begin
          col = 0;
          for (int i = 0; i < NPIX; i++) exp_q.push_back('{W, i, i == 0, (i % X) == X - 1, i == NPIX - 1});
          W++;
        end
      end
      if (held) begin
        chk("hold_valid", bus.pix_valid, 1);
        chk("hold_sof", bus.pix_sof, h_sof);
        chk("hold_eol", bus.pix_eol, h_eol);
      end
      if (bus.pix_valid && !bus.pix_ready) chk("rd_en_stall", bus.rd_en, 0);
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_q.size() == 0) fail("pix_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("pix_frame", d_fr, e.fr);
          chk("pix_addr", d_addr, e.addr);
          chk("pix_sof", bus.pix_sof, e.sof);
          chk("pix_eol", bus.pix_eol, e.eol);
          chk("frame_done", bus.frame_done, e.last);
          if (e.last) R++;
        end
      end else chk("frame_done_idle", bus.frame_done, 0);
      held = bus.pix_valid && !bus.pix_ready;
      h_sof = bus.pix_sof;
      h_eol = bus.pix_eol;
      if (bus.rd_en) begin
        d_fr = mem[bus.rd_bank][bus.rd_addr % X];
        d_addr = int'(bus.rd_addr);
      end
    end
  end
  task automatic cyc(input logic cv, input logic pr);
    bus.col_valid = cv;
    bus.pix_ready = pr;
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    bus.col_valid = 1'b0;
    bus.pix_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && W == R && !bus.pix_valid) && n < 6000);
    if (n >= 6000) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rd(input int a);
    int n = 0;
    bus.col_valid = 1'b0;
    bus.pix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rd_en && int'(bus.rd_addr) == a) break;
      if (++n > 3000) begin
        fail("wait_rd_timeout");
        break;
      end
    end
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_pix_valid"}, bus.pix_valid, 0);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_bank_full"}, bus.bank_full, 0);
    chk({tag, "_wr_col"}, bus.wr_col, 0);
    chk({tag, "_wr_bank"}, bus.wr_bank, 0);
    chk({tag, "_rd_bank"}, bus.rd_bank, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_sof"}, bus.pix_sof, 0);
  endtask
  initial begin
    int npv, nfd;
    rst_n = 1'b0;
    bus.col_valid = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cleared("reset");
    chk("reset_col_accept", bus.col_accept, 1);
`ifdef DROP_COUNT_EN
    chk("reset_drop_count", drop_count, 0);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < X; i++) cyc(1'b1, 1'b1);
    bus.col_valid = 1'b0;
    @(negedge clk);
    chk("full_bank0", bus.bank_full, 2'b01);
    chk("lat_pv0", bus.pix_valid, 0);
    @(negedge clk);
    chk("lat_pv1", bus.pix_valid, 0);
    chk("first_rd_en", bus.rd_en, 1);
    chk("first_rd_addr", bus.rd_addr, 0);
    npv = 0;
    nfd = 0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      npv += int'(bus.pix_valid);
      nfd += int'(bus.frame_done);
      if (i == 0) chk("first_sof", bus.pix_sof, 1);
    end
    @(negedge clk);
    chk("pv_after_frame", bus.pix_valid, 0);
    chk("contiguous_pixels", npv, NPIX);
    chk("frame_done_once", nfd, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2 * X + 1; i++) cyc(1'b1, 1'b0);
    bus.col_valid = 1'b0;
    @(negedge clk);
    chk("both_full", bus.bank_full, 2'b11);
    chk("full_reject", bus.col_accept, 0);
`ifdef DROP_COUNT_EN
    chk("drop_count_one", drop_count, 1);
`endif
    @(posedge clk);
    #1;
    drain();
    for (int k = 0; k < 1800; k++) cyc(k < X, (k % 3) == 0);
    drain();
    for (int i = 0; i < X + 5; i++) cyc(1'b1, 1'b1);
    wait_rd(5 * X + 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_reset");
    chk("async_reset_col_accept", bus.col_accept, 0);
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_wr_bank", bus.wr_bank, 0);
    chk("restart_wr_col", bus.wr_col, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2 * X - 1; i++) cyc(1'b1, 1'b1);
    wait_rd(NPIX - 1);
    @(posedge clk);
    #1;
    bus.col_valid = 1'b1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    chk("sim_frame_done", bus.frame_done, 1);
    chk("sim_wr_en", bus.wr_en, 1);
    chk("sim_wr_col", bus.wr_col, X - 1);
    chk("sim_wr_bank", bus.wr_bank, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sim_after_bank_full", bus.bank_full, 2'b10);
    chk("sim_after_accept", bus.col_accept, 1);
    chk("sim_after_wr_en", bus.wr_en, 1);
    chk("sim_after_wr_bank", bus.wr_bank, 0);
    chk("sim_after_wr_col", bus.wr_col, 0);
    @(posedge clk);
    #1;
    drain();
    for (int k = 0; k < 3000; k++) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
